mux_n_arb: RTL and testbench
============================

MUX_N_ARB -- requirements
Module: mux_n_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each channel in bits.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (2..16, not required to be a power of two).
REQ-003 SHALL have derived localparam SEL_W = max(1, ceil(log2(CHANNELS))), width of select and channel index.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mode  input  1  0 = direct select, 1 = round-robin arbitration.
REQ-007 SHALL have port sel  input  SEL_W  channel index used in direct mode.
REQ-008 SHALL have port in_data  input  CHANNELS*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid  input  CHANNELS  per-channel valid.
REQ-010 SHALL have port in_ready  output  CHANNELS  per-channel ready; at most one bit set.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 SHALL have port out_chan  output  SEL_W  index of channel that produced out_data.

Function
REQ-015 SHALL define load_en = !out_valid || out_ready (output register empty or being drained).
REQ-016 Direct mode: SHALL grant channel sel iff sel < CHANNELS and in_valid[sel]=1; otherwise no grant.
REQ-017 Round-robin mode: SHALL grant the first channel with in_valid=1 searching from rr_ptr upward, wrapping CHANNELS-1 -> 0; no grant if in_valid is all zero.
REQ-018 in_ready[g] SHALL be 1 only when load_en=1 and channel g is granted; all other bits 0 (combinational, same cycle).
REQ-019 A transfer from channel g occurs on an edge where in_valid[g] and in_ready[g] are both 1; next cycle out_data = channel g data, out_chan = g, out_valid = 1 (latency 1 cycle).
REQ-020 When load_en=1 and no grant, out_valid SHALL go 0 on the next edge; out_data and out_chan SHALL hold their prior values.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold and in_ready SHALL be all zero.
REQ-022 Simultaneous drain and load (out_ready=1, grant present) SHALL sustain one word per cycle with no bubble.
REQ-023 rr_ptr (SEL_W bits, internal) SHALL update to (g+1) mod CHANNELS only on a round-robin-mode transfer; direct-mode transfers and idle cycles leave it unchanged.
REQ-024 mode and sel are sampled every cycle; a change takes effect on the same cycle's grant with no drain required; an already registered output word is unaffected.
REQ-025 Data on non-granted channels SHALL never reach out_data.

Reset
REQ-026 While rst=1 on an edge: out_valid=0, out_data=0, out_chan=0, rr_ptr=0; in_ready SHALL be all zero during any cycle rst=1.
REQ-027 Reset asserted with out_valid=1 SHALL discard the pending word; no transfer is accepted in that cycle.
REQ-028 First grant after reset in round-robin mode SHALL search from channel 0.

Verification
REQ-029 Direct: WIDTH=8, CHANNELS=4, in0..in3 = 0xFF,0x00,0x01,0xFE all valid, mode=0, sel=0, out_ready=1 -> one cycle later out_data=0xFF, out_chan=0, out_valid=1; sel=3 -> next word 0xFE, out_chan=3.
REQ-030 Backpressure: out_valid=1, out_ready=0 for 5 cycles with inputs changing -> in_ready=0000, out_data stable; out_ready=1 -> transfer resumes next edge.
REQ-031 Round-robin: all four valid, mode=1, out_ready=1 continuously -> out_chan 0,1,2,3,0 on consecutive cycles, data 0xFF,0x00,0x01,0xFE,0xFF.
REQ-032 Wrap: rr_ptr=3, in_valid=0101 -> grant channel 0 (in_ready=0001), then channel 2, then 0 again.
REQ-033 Invalid select: mode=0, sel=1, in_valid[1]=0, out_ready=1 -> in_ready=0000, out_valid falls to 0 after the held word drains; CHANNELS=3, sel=3 -> no grant.
REQ-034 Reset mid-operation: round-robin streaming, rst=1 for one edge -> out_valid=0, out_data=0, out_chan=0; after release, first output is from channel 0.

Source files
------------

// File: rtl/mux_n_arb.sv
// N-channel registered multiplexer with direct-select and round-robin arbitration modes.
// A single output register is loaded whenever it is empty or being drained.

module mux_n_arb_lane #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] rr_ptr,
  input  logic             valid,
  input  logic             gnt,
  input  logic [WIDTH-1:0] data,
  output logic             req_hi,
  output logic [WIDTH-1:0] data_gated
);
  localparam logic [SEL_W-1:0] IDX_L = SEL_W'(IDX);

  // Requests at or above the pointer win over wrapped-around ones.
  assign req_hi     = valid && (IDX_L >= rr_ptr);
  assign data_gated = gnt ? data : '0;
endmodule

module mux_n_arb #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]                rr_ptr;
  logic                            load_en;
  logic                            gnt_any;
  logic [SEL_W-1:0]                gnt_idx;
  logic                            xfer;
  logic [CHANNELS-1:0]             gnt_vec;
  logic [CHANNELS-1:0]             req_hi;
  logic [CHANNELS-1:0][WIDTH-1:0]  lane_data;
  logic [WIDTH-1:0]                nxt_data;
  logic [SEL_W-1:0]                nxt_ptr;

  assign load_en = !out_valid || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign gnt_vec[gi] = gnt_any && (gnt_idx == SEL_W'(gi));
      mux_n_arb_lane #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .IDX   (gi)
      ) u_lane (
        .rr_ptr     (rr_ptr),
        .valid      (in_valid[gi]),
        .gnt        (gnt_vec[gi]),
        .data       (in_data[gi*WIDTH +: WIDTH]),
        .req_hi     (req_hi[gi]),
        .data_gated (lane_data[gi])
      );
    end
  endgenerate

  // Grant selection. Direct mode matches sel against real channel indices only,
  // so an out-of-range sel yields no grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Lowest valid overall, then overridden by the lowest valid at/above rr_ptr.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (req_hi[i]) gnt_idx = SEL_W'(i);
      end
    end
  end

  assign xfer     = gnt_any && load_en && !rst;
  assign in_ready = xfer ? gnt_vec : '0;
  assign nxt_ptr  = (gnt_idx == LAST) ? '0 : gnt_idx + SEL_W'(1);

  always_comb begin
    nxt_data = '0;
    for (int i = 0; i < CHANNELS; i++) nxt_data = nxt_data | lane_data[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_data <= nxt_data;
        out_chan <= gnt_idx;
        if (mode) rr_ptr <= nxt_ptr;
      end
    end
  end
endmodule

// File: tb/tb_mux_n_arb.sv
// Randomized and directed bench for mux_n_arb against a behavioural reference model.
module tb_mux_n_arb;
  localparam int CH = 4;

  logic             clk = 1'b0;
  logic             rst, mode, out_ready;
  logic [1:0]       sel;
  logic [CH-1:0][7:0] in_d;
  logic [CH-1:0]    in_valid, in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic [1:0]       out_chan;

  logic [1:0]       sel3;
  logic [2:0][7:0]  in_d3;
  logic [2:0]       in_valid3, in_ready3;
  logic [7:0]       out_data3;
  logic             out_valid3;
  logic [1:0]       out_chan3;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       m_valid = 0;
  bit [7:0] m_data  = 0;
  int       m_chan  = 0;
  int       m_ptr   = 0;

  bit [7:0] canon [CH] = '{8'hFF, 8'h00, 8'h01, 8'hFE};

  always #5 clk = ~clk;

  mux_n_arb #(.WIDTH(8), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_d),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
  );

  mux_n_arb #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel3), .in_data(in_d3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_chan(out_chan3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_grant(output bit any, output int g);
    any = 0;
    g   = 0;
    if (rst) return;
    if (!mode) begin
      if (int'(sel) < CH && in_valid[sel]) begin
        any = 1;
        g   = int'(sel);
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (m_ptr + k) % CH;
        if (!any && in_valid[c]) begin
          any = 1;
          g   = c;
        end
      end
    end
  endfunction

  // One clock: check combinational ready, advance the model across the edge, check outputs.
  task automatic step();
    bit        any;
    int        g;
    bit        le;
    logic [CH-1:0] exp_rdy;
    #1;
    model_grant(any, g);
    le = !m_valid || out_ready;
    exp_rdy = '0;
    if (!rst && le && any) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
    end else if (le) begin
      m_valid = any;
      if (any) begin
        m_data = in_d[g];
        m_chan = g;
        if (mode) m_ptr = (g + 1) % CH;
      end
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_chan", out_chan, m_chan);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; mode = 0; sel = 0; in_valid = '0; in_d = '0; out_ready = 1;
    sel3 = 0; in_valid3 = '0; in_d3 = '0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_ready", in_ready, 0);
    rst = 0;

    // Direct select
    for (int i = 0; i < CH; i++) in_d[i] = canon[i];
    in_valid = 4'hF; mode = 0; sel = 0;
    step();
    chk("dir_data0", out_data, 8'hFF);
    chk("dir_chan0", out_chan, 0);
    chk("dir_valid0", out_valid, 1);
    sel = 3;
    step();
    chk("dir_data3", out_data, 8'hFE);
    chk("dir_chan3", out_chan, 3);

    // Backpressure with changing inputs
    out_ready = 0; sel = 1;
    for (int k = 0; k < 5; k++) begin
      in_d[0] = 8'($urandom);
      in_d[2] = 8'($urandom);
      step();
      chk("bp_ready", in_ready, 0);
      chk("bp_data", out_data, 8'hFE);
    end
    out_ready = 1;
    step();
    chk("bp_resume_data", out_data, 8'h00);
    chk("bp_resume_chan", out_chan, 1);
    for (int i = 0; i < CH; i++) in_d[i] = canon[i];

    // Round-robin streaming from pointer 0
    mode = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_chan", out_chan, k % CH);
      chk("rr_data", out_data, canon[k % CH]);
    end

    // Wrap from pointer 3
    in_valid = 4'b0100;
    step();
    chk("wrap_pre", out_chan, 2);
    in_valid = 4'b0101;
    #1;
    chk("wrap_ready", in_ready, 4'b0001);
    step(); chk("wrap_c0", out_chan, 0);
    step(); chk("wrap_c2", out_chan, 2);
    step(); chk("wrap_c0b", out_chan, 0);

    // Invalid select drains the held word then goes idle
    mode = 0; sel = 1; in_valid = 4'b1101; out_ready = 0;
    step();
    chk("inv_hold", out_valid, 1);
    out_ready = 1;
    step();
    chk("inv_ready", in_ready, 0);
    chk("inv_idle", out_valid, 0);

    // Three-channel instance: sel beyond CHANNELS
    sel3 = 3; in_valid3 = 3'b111; in_d3 = {8'h33, 8'h22, 8'h11};
    #1;
    chk("ch3_sel3_ready", in_ready3, 0);
    step();
    chk("ch3_sel3_valid", out_valid3, 0);
    sel3 = 2;
    #1;
    chk("ch3_sel2_ready", in_ready3, 3'b100);
    step();
    chk("ch3_sel2_valid", out_valid3, 1);
    chk("ch3_sel2_data", out_data3, 8'h33);
    chk("ch3_sel2_chan", out_chan3, 2);

    // Reset mid-stream
    mode = 1; in_valid = 4'hF; out_ready = 1;
    step(); step(); step();
    rst = 1;
    #1;
    chk("rst_mid_ready", in_ready, 0);
    step();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_chan", out_chan, 0);
    rst = 0;
    step();
    chk("rst_first_chan", out_chan, 0);
    chk("rst_first_data", out_data, 8'hFF);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < CH; i++) in_d[i] = 8'($urandom);
      in_valid  = 4'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
